video_timing_gen: RTL and testbench

- Parametrised raster timing generator for the menu/loader cores; runs on the pixel clock.
- Produces H/V counters, blank and sync strobes (15 kHz and 31 kHz hsync widths), and frame/line pulses.
- Produces a registered framebuffer byte address with optional vertical flip for bottom-up BMP data in SDRAM.
- Produces a per-frame phase accumulator for animated fill patterns.
- PAL/NTSC line count is selectable at runtime; a mode change takes effect only at a frame boundary.

---
 rtl/video_timing_gen.sv | 243 ++++++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
`default_nettype none
//==============================================================================
// Module : video_timing_gen
// Desc   : Raster timing generator: H/V counters, blank/sync strobes, line and
//          frame pulses, flip-capable framebuffer address and frame phase.
// Rev    : 1.0 - initial release
//==============================================================================
module video_timing_gen #(
    parameter int HCNT_W       = 10,
    parameter int VCNT_W       = 9,
    parameter int H_ACTIVE     = 640,
    parameter int H_TOTAL      = 800,
    parameter int HS_START     = 655,
    parameter int HS_W_15K     = 64,
    parameter int HS_W_31K     = 96,
    parameter int BLANK_DLY    = 2,
    parameter int V_TOTAL_PAL  = 312,
    parameter int V_TOTAL_NTSC = 262,
    parameter int VS_LEAD      = 3,
    parameter int VB_TOP       = 2,
    parameter int VB_BOT       = 5,
    parameter int ADDR_W       = 23,
    parameter int BPP_SHIFT    = 2,
    parameter int FLIP_V       = 1,
    parameter int PHASE_STEP   = 6,
    parameter int PHASE_W      = 10
) (
    input  logic              clk_pix,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic              ntsc,
    output logic [HCNT_W-1:0] hc,
    output logic [VCNT_W-1:0] vc,
    output logic [VCNT_W-1:0] line_max,
    output logic              hblank,
    output logic              vblank,
    output logic              hsync,
    output logic              hsync_vga,
    output logic              vsync,
    output logic              line_start,
    output logic              frame_start,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [PHASE_W-1:0] phase,
    output logic [15:0]       frame_cnt
);

    localparam logic [HCNT_W-1:0] c_H_ONE    = HCNT_W'(1);
    localparam logic [HCNT_W-1:0] c_H_LAST   = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] c_HB_SET   = HCNT_W'(H_ACTIVE + BLANK_DLY);
    localparam logic [HCNT_W-1:0] c_HB_CLR   = HCNT_W'(BLANK_DLY);
    localparam logic [HCNT_W-1:0] c_HS_SET   = HCNT_W'(HS_START);
    localparam logic [HCNT_W-1:0] c_HS_CLR   = HCNT_W'(HS_START + HS_W_15K);
    localparam logic [HCNT_W-1:0] c_HSV_CLR  = HCNT_W'(HS_START + HS_W_31K);
    localparam logic [VCNT_W-1:0] c_V_ONE    = VCNT_W'(1);
    localparam logic [VCNT_W-1:0] c_VT_PAL   = VCNT_W'(V_TOTAL_PAL);
    localparam logic [VCNT_W-1:0] c_VT_NTSC  = VCNT_W'(V_TOTAL_NTSC);
    localparam logic [VCNT_W-1:0] c_VB_TOP   = VCNT_W'(VB_TOP);
    localparam logic [VCNT_W-1:0] c_VB_BOT   = VCNT_W'(VB_BOT);
    localparam logic [VCNT_W-1:0] c_VS_LEAD  = VCNT_W'(VS_LEAD);
    localparam logic [PHASE_W-1:0] c_PHASE_STEP = PHASE_W'(PHASE_STEP);

    localparam int c_MATH_MIN = VCNT_W + HCNT_W + BPP_SHIFT + 1;
    localparam int c_MATH_W   = (ADDR_W > c_MATH_MIN) ? ADDR_W : c_MATH_MIN;

    // Video standard, latched only at the frame wrap
    localparam logic [0:0] S_PAL  = 1'b0;
    localparam logic [0:0] S_NTSC = 1'b1;

    if (H_ACTIVE + BLANK_DLY >= H_TOTAL) begin : g_chk_hblank
        $error("video_timing_gen: H_ACTIVE+BLANK_DLY must be below H_TOTAL");
    end
    if (HS_START + HS_W_31K >= H_TOTAL) begin : g_chk_hsync
        $error("video_timing_gen: HS_START+HS_W_31K must be below H_TOTAL");
    end

    logic [0:0]        r_mode;
    logic [0:0]        w_mode_next;
    logic [VCNT_W-1:0] w_line_max;

    logic [HCNT_W-1:0] r_hc;
    logic [VCNT_W-1:0] r_vc;
    logic              r_hblank;
    logic              r_vblank;
    logic              r_hsync;
    logic              r_hsync_vga;
    logic              r_vsync;
    logic              r_line_start;
    logic              r_frame_start;
    logic [ADDR_W-1:0] r_pix_addr;
    logic [PHASE_W-1:0] r_phase;
    logic [15:0]       r_frame_cnt;

    logic              w_h_wrap;
    logic              w_v_wrap;
    logic              w_frame_wrap;
    logic [VCNT_W-1:0] w_vb_set_line;
    logic [VCNT_W-1:0] w_vs_set_line;
    logic [VCNT_W-1:0] w_row;
    logic [ADDR_W-1:0] w_addr_next;

    // Mode state machine: register / next-state / output
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= S_PAL;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        if (ce_pix && w_frame_wrap) begin
            w_mode_next = ntsc ? S_NTSC : S_PAL;
        end
    end

    always_comb begin
        w_line_max = c_VT_PAL;
        case (r_mode)
            S_NTSC:  w_line_max = c_VT_NTSC;
            default: w_line_max = c_VT_PAL;
        endcase
    end

    assign w_h_wrap      = (r_hc == c_H_LAST);
    assign w_v_wrap      = (r_vc == (w_line_max - c_V_ONE));
    assign w_frame_wrap  = w_h_wrap && w_v_wrap;
    assign w_vb_set_line = w_line_max - c_VB_BOT;
    assign w_vs_set_line = w_line_max - c_VS_LEAD;

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (ce_pix) begin
            if (w_h_wrap) begin
                r_hc <= '0;
                if (w_v_wrap) begin
                    r_vc <= '0;
                end else begin
                    r_vc <= r_vc + c_V_ONE;
                end
            end else begin
                r_hc <= r_hc + c_H_ONE;
            end
        end
    end

    // Strobes compare the pre-increment counts, so each edge lands one ce late
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            r_hblank    <= 1'b1;
            r_vblank    <= 1'b1;
            r_hsync     <= 1'b0;
            r_hsync_vga <= 1'b0;
            r_vsync     <= 1'b0;
        end else if (ce_pix) begin
            if (r_hc == c_HB_SET) begin
                r_hblank <= 1'b1;
            end else if (r_hc == c_HB_CLR) begin
                r_hblank <= 1'b0;
            end

            if ((r_hc == c_HB_SET) && (r_vc == w_vb_set_line)) begin
                r_vblank <= 1'b1;
            end else if ((r_hc == c_HB_CLR) && (r_vc == c_VB_TOP)) begin
                r_vblank <= 1'b0;
            end

            if (r_hc == c_HS_SET) begin
                r_hsync <= 1'b1;
            end else if (r_hc == c_HS_CLR) begin
                r_hsync <= 1'b0;
            end

            if (r_hc == c_HS_SET) begin
                r_hsync_vga <= 1'b1;
            end else if (r_hc == c_HSV_CLR) begin
                r_hsync_vga <= 1'b0;
            end

            if ((r_hc == c_HS_SET) && (r_vc == w_vs_set_line)) begin
                r_vsync <= 1'b1;
            end else if ((r_hc == c_HSV_CLR) && (r_vc == '0)) begin
                r_vsync <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= ce_pix && w_h_wrap;
            r_frame_start <= ce_pix && w_frame_wrap;
        end
    end

    // Bottom-up BMP rows: line 0 reads the last stored row
    if (FLIP_V != 0) begin : g_flip
        assign w_row = w_line_max - c_V_ONE - r_vc;
    end else begin : g_noflip
        assign w_row = r_vc;
    end

    assign w_addr_next = ADDR_W'(((c_MATH_W'(w_row) * c_MATH_W'(H_ACTIVE))
                                  + c_MATH_W'(r_hc)) << BPP_SHIFT);

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_addr <= '0;
        end else if (ce_pix) begin
            r_pix_addr <= w_addr_next;
        end
    end

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            r_phase     <= '0;
            r_frame_cnt <= '0;
        end else if (ce_pix && w_frame_wrap) begin
            r_phase     <= r_phase + c_PHASE_STEP;
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign hc          = r_hc;
    assign vc          = r_vc;
    assign line_max    = w_line_max;
    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign hsync       = r_hsync;
    assign hsync_vga   = r_hsync_vga;
    assign vsync       = r_vsync;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign pix_addr    = r_pix_addr;
    assign phase       = r_phase;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
//==============================================================================
// Module : tb_video_timing_gen
// Desc   : Directed bench for video_timing_gen on a shrunken 24x12 / 24x10 raster.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_video_timing_gen;

    localparam int HCNT_W = 10;
    localparam int VCNT_W = 9;
    localparam int ADDR_W = 23;
    localparam int PHASE_W = 10;

    logic               clk_pix;
    logic               reset_n;
    logic               ce_pix;
    logic               ntsc;
    logic [HCNT_W-1:0]  hc;
    logic [VCNT_W-1:0]  vc;
    logic [VCNT_W-1:0]  line_max;
    logic               hblank;
    logic               vblank;
    logic               hsync;
    logic               hsync_vga;
    logic               vsync;
    logic               line_start;
    logic               frame_start;
    logic [ADDR_W-1:0]  pix_addr;
    logic [PHASE_W-1:0] phase;
    logic [15:0]        frame_cnt;

    video_timing_gen #(
        .HCNT_W(HCNT_W), .VCNT_W(VCNT_W), .H_ACTIVE(16), .H_TOTAL(24),
        .HS_START(18), .HS_W_15K(2), .HS_W_31K(4), .BLANK_DLY(2),
        .V_TOTAL_PAL(12), .V_TOTAL_NTSC(10), .VS_LEAD(3), .VB_TOP(2),
        .VB_BOT(5), .ADDR_W(ADDR_W), .BPP_SHIFT(2), .FLIP_V(1),
        .PHASE_STEP(6), .PHASE_W(PHASE_W)
    ) dut (
        .clk_pix(clk_pix), .reset_n(reset_n), .ce_pix(ce_pix), .ntsc(ntsc),
        .hc(hc), .vc(vc), .line_max(line_max), .hblank(hblank), .vblank(vblank),
        .hsync(hsync), .hsync_vga(hsync_vga), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start),
        .pix_addr(pix_addr), .phase(phase), .frame_cnt(frame_cnt)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    typedef struct {
        int k;  int hc; int vc;
        int hb; int vb; int hs; int hsv; int vs; int ls; int fs;
        int addr; int fcnt;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_fs = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk_pix);
        #1;
        cyc++;
        if (frame_start) n_fs++;
    endtask

    task automatic adv_to(input int k);
        while (cyc < k) step();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_hc"}, hc, 0);           chk({tag, "_vc"}, vc, 0);
        chk({tag, "_line_max"}, line_max, 12);
        chk({tag, "_hblank"}, hblank, 1);   chk({tag, "_vblank"}, vblank, 1);
        chk({tag, "_hsync"}, hsync, 0);     chk({tag, "_hsync_vga"}, hsync_vga, 0);
        chk({tag, "_vsync"}, vsync, 0);     chk({tag, "_line_start"}, line_start, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_pix_addr"}, pix_addr, 0);
        chk({tag, "_phase"}, phase, 0);     chk({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    initial begin
        int guard;
        int cnt;

        //          k   hc vc hb vb hs hsv vs ls fs addr fcnt
        tbl.push_back('{  1,  1, 0, 1, 1, 0, 0, 0, 0, 0, 704, 0});
        tbl.push_back('{  3,  3, 0, 0, 1, 0, 0, 0, 0, 0, 712, 0});
        tbl.push_back('{  6,  6, 0, 0, 1, 0, 0, 0, 0, 0, 724, 0});
        tbl.push_back('{ 19, 19, 0, 1, 1, 1, 1, 0, 0, 0, 776, 0});
        tbl.push_back('{ 21, 21, 0, 1, 1, 0, 1, 0, 0, 0, 784, 0});
        tbl.push_back('{ 23, 23, 0, 1, 1, 0, 0, 0, 0, 0, 792, 0});
        tbl.push_back('{ 24,  0, 1, 1, 1, 0, 0, 0, 1, 0, 796, 0});
        tbl.push_back('{ 25,  1, 1, 1, 1, 0, 0, 0, 0, 0, 640, 0});
        tbl.push_back('{ 50,  2, 2, 1, 1, 0, 0, 0, 0, 0, 580, 0});
        tbl.push_back('{ 51,  3, 2, 0, 0, 0, 0, 0, 0, 0, 584, 0});
        tbl.push_back('{186, 18, 7, 0, 0, 0, 0, 0, 0, 0, 324, 0});
        tbl.push_back('{187, 19, 7, 1, 1, 1, 1, 0, 0, 0, 328, 0});
        tbl.push_back('{234, 18, 9, 0, 1, 0, 0, 0, 0, 0, 196, 0});
        tbl.push_back('{235, 19, 9, 1, 1, 1, 1, 1, 0, 0, 200, 0});
        tbl.push_back('{286, 22,11, 1, 1, 0, 1, 1, 0, 0,  84, 0});
        tbl.push_back('{287, 23,11, 1, 1, 0, 0, 1, 0, 0,  88, 0});
        tbl.push_back('{288,  0, 0, 1, 1, 0, 0, 1, 1, 1,  92, 1});
        tbl.push_back('{289,  1, 0, 1, 1, 0, 0, 1, 0, 0, 704, 1});
        tbl.push_back('{310, 22, 0, 1, 1, 0, 1, 1, 0, 0, 788, 1});
        tbl.push_back('{311, 23, 0, 1, 1, 0, 0, 0, 0, 0, 792, 1});

        reset_n = 1'b0;
        ce_pix  = 1'b0;
        ntsc    = 1'b0;
        repeat (3) step();
        check_reset_state("rst");
        reset_n = 1'b1;
        ce_pix  = 1'b1;
        cyc     = 0;

        // First PAL frame, free running
        foreach (tbl[i]) begin
            adv_to(tbl[i].k);
            chk($sformatf("v%0d_hc", i), hc, tbl[i].hc);
            chk($sformatf("v%0d_vc", i), vc, tbl[i].vc);
            chk($sformatf("v%0d_hblank", i), hblank, tbl[i].hb);
            chk($sformatf("v%0d_vblank", i), vblank, tbl[i].vb);
            chk($sformatf("v%0d_hsync", i), hsync, tbl[i].hs);
            chk($sformatf("v%0d_hsync_vga", i), hsync_vga, tbl[i].hsv);
            chk($sformatf("v%0d_vsync", i), vsync, tbl[i].vs);
            chk($sformatf("v%0d_line_start", i), line_start, tbl[i].ls);
            chk($sformatf("v%0d_frame_start", i), frame_start, tbl[i].fs);
            chk($sformatf("v%0d_pix_addr", i), pix_addr, tbl[i].addr);
            chk($sformatf("v%0d_frame_cnt", i), frame_cnt, tbl[i].fcnt);
            chk($sformatf("v%0d_phase", i), phase, tbl[i].fcnt * 6);
            chk($sformatf("v%0d_line_max", i), line_max, 12);
        end

        // ntsc toggled mid-frame: only the value at the wrap counts
        adv_to(288 + 4 * 24);  ntsc = 1'b1;
        adv_to(288 + 5 * 24);  ntsc = 1'b0;
        adv_to(288 + 6 * 24);  ntsc = 1'b1;
        adv_to(575);
        chk("lm_before_wrap", line_max, 12);
        chk("fs_before_wrap", frame_start, 0);
        step();
        chk("ntsc_wrap_fs", frame_start, 1);
        chk("ntsc_wrap_lm", line_max, 10);
        chk("ntsc_wrap_fcnt", frame_cnt, 2);
        chk("ntsc_wrap_phase", phase, 12);
        chk("ntsc_wrap_vc", vc, 0);
        adv_to(576 + 6);
        chk("ntsc_addr", pix_addr, 596);
        adv_to(576 + 5 * 24 + 18);
        chk("ntsc_vblank_pre", vblank, 0);
        step();
        chk("ntsc_vblank_set", vblank, 1);
        adv_to(576 + 7 * 24 + 19);
        chk("ntsc_vsync_set", vsync, 1);
        adv_to(576 + 8 * 24);  ntsc = 1'b0;
        adv_to(576 + 9 * 24);  ntsc = 1'b1;
        adv_to(815);
        chk("ntsc_len_fs_early", frame_start, 0);
        step();
        chk("ntsc_len_fs", frame_start, 1);
        chk("ntsc_stay_lm", line_max, 10);
        adv_to(820);  ntsc = 1'b0;
        adv_to(1055);
        chk("ntsc2_fs_early", frame_start, 0);
        step();
        chk("pal_back_fs", frame_start, 1);
        chk("pal_back_lm", line_max, 12);

        // ce_pix low: pulses drop, everything else freezes
        ce_pix = 1'b0;
        step();
        chk("ce0_hc", hc, 0);
        chk("ce0_ls", line_start, 0);
        chk("ce0_fs", frame_start, 0);
        ce_pix = 1'b1;
        repeat (19) step();
        chk("pre_freeze_hc", hc, 19);
        chk("pre_freeze_addr", pix_addr, 776);
        ce_pix = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("freeze_hc", hc, 19);
            chk("freeze_vc", vc, 0);
            chk("freeze_hsync", hsync, 1);
            chk("freeze_hsync_vga", hsync_vga, 1);
            chk("freeze_addr", pix_addr, 776);
            chk("freeze_ls", line_start, 0);
        end
        ce_pix = 1'b1;
        step();
        chk("resume_hc", hc, 20);
        chk("resume_hsync", hsync, 1);
        step();
        chk("resume2_hc", hc, 21);
        chk("resume2_hsync", hsync, 0);
        chk("resume2_hsync_vga", hsync_vga, 1);
        chk("resume2_addr", pix_addr, 784);

        // Run to 171 completed frames
        guard = 0;
        while (n_fs < 171 && guard < 60000) begin
            step();
            guard++;
        end
        chk("frames_171_reached", n_fs, 171);
        chk("phase_171", phase, 2);
        chk("fcnt_171", frame_cnt, 171);

        // Put the DUT into NTSC, then reset mid-frame
        ntsc = 1'b1;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!frame_start && cnt < 400);
        chk("pre_rst_fs", frame_start, 1);
        chk("pre_rst_lm", line_max, 10);
        repeat (6 * 24 + 10) step();
        chk("pre_rst_hc", hc, 10);
        chk("pre_rst_vc", vc, 6);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        step();
        step();
        reset_n = 1'b1;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!frame_start && cnt < 1000);
        chk("post_rst_frame_len", cnt, 288);
        chk("post_rst_lm", line_max, 10);
        chk("post_rst_fcnt", frame_cnt, 1);
        chk("post_rst_phase", phase, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
